// File: rtl/dot_product_row_feeder_pkg.sv
// Shared types and constants for the dot-product row feeder and its address generator.
package dot_product_row_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int TIMEOUT_DEFAULT = 1024;

    function automatic int pkg_w(input int ni);
        return 32 * ni;
    endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Latches a job's base addresses and package count, and tracks which package is
// streaming along with its current and prefetch read addresses.
module feeder_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [31:0]       count,
    output logic [31:0]       count_q,
    output logic [31:0]       pkg_idx,
    output logic [ADDR_W-1:0] addr_a_cur,
    output logic [ADDR_W-1:0] addr_b_cur,
    output logic [ADDR_W-1:0] addr_a_next,
    output logic [ADDR_W-1:0] addr_b_next,
    output logic              last,
    output logic              zero_count
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] idx_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_a_q <= '0;
            base_b_q <= '0;
            count_q  <= '0;
            pkg_idx  <= '0;
        end else if (load) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            count_q  <= count;
            pkg_idx  <= '0;
        end else if (advance) begin
            pkg_idx <= pkg_idx + 32'd1;
        end
    end

    // Only the low bits of the counter feed the address, so rows wrap modulo 2^ADDR_W.
    assign idx_lo      = pkg_idx[ADDR_W-1:0];
    assign addr_a_cur  = base_a_q + idx_lo;
    assign addr_b_cur  = base_b_q + idx_lo;
    assign addr_a_next = base_a_q + idx_lo + ONE;
    assign addr_b_next = base_b_q + idx_lo + ONE;
    assign last        = (pkg_idx == count_q - 32'd1);
    assign zero_count  = (count_q == 32'd0);

endmodule

// File: rtl/dot_product_row_feeder.sv
// Streams packages of two rows from synchronous memories into a dot-product unit,
// each package held two cycles, then collects the unit's result with a watchdog.
module dot_product_row_feeder
    import dot_product_row_feeder_pkg::*;
#(
    parameter int NI      = 8,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr_a,
    input  logic [ADDR_W-1:0]      base_addr_b,
    input  logic [31:0]            no_of_multiples,
    output logic [ADDR_W-1:0]      mem_addr_a,
    output logic [ADDR_W-1:0]      mem_addr_b,
    input  logic [pkg_w(NI)-1:0]   mem_data_a,
    input  logic [pkg_w(NI)-1:0]   mem_data_b,
    output logic [pkg_w(NI)-1:0]   first_row_input,
    output logic [pkg_w(NI)-1:0]   second_row_input,
    output logic                   outsider_read_now,
    output logic [31:0]            dp_no_of_multiples,
    output logic                   dp_reset,
    input  logic                   finish,
    input  logic [31:0]            dot_product_output,
    output logic [31:0]            result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   timeout_err,
    output state_t                 dbg_state
);

    localparam int          PKG_W      = pkg_w(NI);
    localparam logic [31:0] DRAIN_LAST = 32'(TIMEOUT - 1);

    // Handshake: start is a one-cycle request taken only in IDLE; finish is a level
    // sampled only in DRAIN. Every other occurrence of either is ignored.

    state_t            state, state_nxt;
    logic              phase, phase_nxt;
    logic              load, advance, rd_cur, rd_next;
    logic              row_load, row_clear, capture, expire, zero_done;
    logic [31:0]       pkg_idx, count_q, drain_cnt;
    logic [ADDR_W-1:0] addr_a_cur, addr_b_cur, addr_a_next, addr_b_next;
    logic              last, zero_count;
    logic [PKG_W-1:0]  row_a, row_b;
    logic [31:0]       result_q;
    logic              timeout_q;

    feeder_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .base_a      (base_addr_a),
        .base_b      (base_addr_b),
        .count       (no_of_multiples),
        .count_q     (count_q),
        .pkg_idx     (pkg_idx),
        .addr_a_cur  (addr_a_cur),
        .addr_b_cur  (addr_b_cur),
        .addr_a_next (addr_a_next),
        .addr_b_next (addr_b_next),
        .last        (last),
        .zero_count  (zero_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // phase splits CLEAR, FETCH and STREAM into two-cycle units: address/upper half
    // first, data arrival/lower half second.
    always_comb begin
        state_nxt = state;
        phase_nxt = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        rd_cur    = 1'b0;
        rd_next   = 1'b0;
        row_load  = 1'b0;
        row_clear = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        zero_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                phase_nxt = ~phase;
                if (phase) begin
                    zero_done = zero_count;
                    state_nxt = zero_count ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                phase_nxt = ~phase;
                rd_cur    = ~phase;
                if (phase) begin
                    row_load  = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                phase_nxt = ~phase;
                rd_next   = ~phase & ~last;
                if (phase) begin
                    if (last) begin
                        row_clear = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        row_load = 1'b1;
                        advance  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (finish) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    expire    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_a     <= '0;
            row_b     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (row_load) begin
                row_a <= mem_data_a;
                row_b <= mem_data_b;
            end else if (row_clear) begin
                row_a <= '0;
                row_b <= '0;
            end
            if (capture) begin
                result_q <= dot_product_output;
            end else if (expire || zero_done) begin
                result_q <= '0;
            end
            if (load) begin
                timeout_q <= 1'b0;
            end else if (expire) begin
                timeout_q <= 1'b1;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 32'd1 : 32'd0;
        end
    end

    assign mem_addr_a = rd_cur ? addr_a_cur : (rd_next ? addr_a_next : '0);
    assign mem_addr_b = rd_cur ? addr_b_cur : (rd_next ? addr_b_next : '0);

    assign first_row_input    = row_a;
    assign second_row_input   = row_b;
    assign outsider_read_now  = (state == S_STREAM) && !phase && (pkg_idx == 32'd0);
    assign dp_no_of_multiples = count_q;
    // The consumer is also held clear for as long as our own reset is asserted.
    assign dp_reset           = (state == S_CLEAR) || !reset;
    assign result             = result_q;
    assign result_valid       = (state == S_DONE);
    assign busy               = (state != S_IDLE);
    assign timeout_err        = timeout_q;
    assign dbg_state          = state;

endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Self-checking bench for dot_product_row_feeder: random rows in a behavioural memory,
// expected per-cycle behaviour derived from the job timeline and row contents.
module tb_dot_product_row_feeder;
    import dot_product_row_feeder_pkg::*;

    localparam int NI      = 8;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;
    localparam int PW      = 32 * NI;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAXC    = 128;

    logic              clk, reset, start, finish;
    logic [ADDR_W-1:0] base_addr_a, base_addr_b, mem_addr_a, mem_addr_b;
    logic [31:0]       no_of_multiples, dp_no_of_multiples, dot_product_output, result;
    logic [PW-1:0]     mem_data_a, mem_data_b, first_row_input, second_row_input;
    logic              outsider_read_now, dp_reset, result_valid, busy, timeout_err;
    state_t            dbg_state;

    dot_product_row_feeder #(.NI(NI), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .base_addr_a        (base_addr_a),
        .base_addr_b        (base_addr_b),
        .no_of_multiples    (no_of_multiples),
        .mem_addr_a         (mem_addr_a),
        .mem_addr_b         (mem_addr_b),
        .mem_data_a         (mem_data_a),
        .mem_data_b         (mem_data_b),
        .first_row_input    (first_row_input),
        .second_row_input   (second_row_input),
        .outsider_read_now  (outsider_read_now),
        .dp_no_of_multiples (dp_no_of_multiples),
        .dp_reset           (dp_reset),
        .finish             (finish),
        .dot_product_output (dot_product_output),
        .result             (result),
        .result_valid       (result_valid),
        .busy               (busy),
        .timeout_err        (timeout_err),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [PW-1:0] mem_a [DEPTH];
    logic [PW-1:0] mem_b [DEPTH];

    always @(posedge clk) begin
        mem_data_a <= mem_a[mem_addr_a];
        mem_data_b <= mem_b[mem_addr_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle record of one job; index 0 is the first cycle after start is taken.
    logic              rec_dpr  [MAXC];
    logic              rec_rn   [MAXC];
    logic              rec_busy [MAXC];
    logic              rec_rv   [MAXC];
    logic              rec_terr [MAXC];
    logic [ADDR_W-1:0] rec_aa   [MAXC];
    logic [ADDR_W-1:0] rec_ab   [MAXC];
    logic [PW-1:0]     rec_ra   [MAXC];
    logic [PW-1:0]     rec_rb   [MAXC];
    logic [31:0]       rec_res  [MAXC];
    int                done_idx, n_rec;

    // ---------------- reference model ----------------
    function automatic logic [31:0] f32_of(input int v);
        logic [31:0] u, m;
        int e;
        if (v <= 0) return 32'h0;
        u = v;
        e = 0;
        for (int b = 0; b < 24; b++) if (u[b]) e = b;
        m = u << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int int_of_f32(input logic [31:0] f);
        logic [31:0] mant;
        int e;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]) - 127;
        mant = {8'h0, 1'b1, f[22:0]};
        return int'(mant >> (23 - e));
    endfunction

    function automatic int model_dot(input int ba, input int bb, input int cnt);
        int acc;
        logic [PW-1:0] wa, wb;
        acc = 0;
        for (int k = 0; k < cnt; k++) begin
            wa = mem_a[(ba + k) % DEPTH];
            wb = mem_b[(bb + k) % DEPTH];
            for (int i = 0; i < NI; i++)
                acc += int_of_f32(wa[32*i +: 32]) * int_of_f32(wb[32*i +: 32]);
        end
        return acc;
    endfunction

    // ---------------- driver ----------------
    // Runs one job; fin_at is the DRAIN cycle in which finish is raised (-1: never).
    task automatic drive_job(input int ba, input int bb, input int cnt, input int fin_at,
                             input bit hold_start, input bit stray_finish, input logic [31:0] dp_val);
        int drain_idx, fin_idx;
        drain_idx = 4 + 2 * cnt;
        fin_idx   = (fin_at < 0) ? -1 : drain_idx + fin_at;
        done_idx  = -1;
        n_rec     = 0;
        @(negedge clk);
        base_addr_a     = ADDR_W'(ba);
        base_addr_b     = ADDR_W'(bb);
        no_of_multiples = 32'(cnt);
        start           = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            @(negedge clk);
            start              = hold_start && (i <= drain_idx);
            finish             = (i == fin_idx) || (stray_finish && i == 5);
            dot_product_output = (i == fin_idx) ? dp_val : 32'hDEAD_BEEF;
            rec_dpr[i]  = dp_reset;
            rec_rn[i]   = outsider_read_now;
            rec_busy[i] = busy;
            rec_rv[i]   = result_valid;
            rec_terr[i] = timeout_err;
            rec_aa[i]   = mem_addr_a;
            rec_ab[i]   = mem_addr_b;
            rec_ra[i]   = first_row_input;
            rec_rb[i]   = second_row_input;
            rec_res[i]  = result;
            n_rec       = i + 1;
            if (rec_rv[i] && done_idx < 0) done_idx = i;
            if (done_idx >= 0 && i >= done_idx + 3) break;
        end
        start  = 1'b0;
        finish = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, outsider_read_now, result_valid, timeout_err, dp_reset} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00001", {busy, outsider_read_now, result_valid, timeout_err, dp_reset});
        end
        n_cmp++;
        if ({first_row_input, second_row_input} !== '0 || {mem_addr_a, mem_addr_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_rows_addr: rows/addrs not zero (addr_a %h addr_b %h)", mem_addr_a, mem_addr_b);
        end
        n_cmp++;
        if ({result, dp_no_of_multiples} !== 64'h0 || dbg_state !== S_IDLE) begin
            n_bad++;
            $display("FAIL reset_regs: result %h count %h state %0d want 0 0 IDLE", result, dp_no_of_multiples, dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, dp_reset} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy/dp_reset %b want 00", {busy, dp_reset});
        end
    endtask

    task automatic test_directed_48();
        int rn_cnt, rv_cnt;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NI; i++) begin
                mem_a[100 + k][32*i +: 32] = f32_of(k + 1);
                mem_b[200 + k][32*i +: 32] = f32_of(1);
            end
        drive_job(100, 200, 3, 2, 1'b0, 1'b0, f32_of(model_dot(100, 200, 3)));
        rn_cnt = 0;
        rv_cnt = 0;
        for (int i = 0; i < n_rec; i++) begin
            rn_cnt += int'(rec_rn[i]);
            rv_cnt += int'(rec_rv[i]);
        end
        n_cmp++;
        if (rn_cnt != 1 || rec_rn[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL d48_read_now: pulses %0d at4=%b want 1 at cycle 4", rn_cnt, rec_rn[4]);
        end
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (rec_ra[4 + j] !== mem_a[100 + j / 2] || rec_rb[4 + j] !== mem_b[200 + j / 2]) begin
                n_bad++;
                $display("FAIL d48_stream cycle %0d: row_a %h want %h", j, rec_ra[4 + j][31:0], mem_a[100 + j / 2][31:0]);
            end
        end
        n_cmp++;
        if (rec_ra[10] !== '0 || rec_rb[10] !== '0) begin
            n_bad++;
            $display("FAIL d48_rows_zero: rows not cleared after last package");
        end
        n_cmp++;
        if (done_idx != 13 || rv_cnt != 1) begin
            n_bad++;
            $display("FAIL d48_done: done at %0d pulses %0d want 13 and 1", done_idx, rv_cnt);
        end
        n_cmp++;
        if (rec_res[13] !== 32'h4240_0000) begin
            n_bad++;
            $display("FAIL d48_result: got %h want 42400000", rec_res[13]);
        end
    endtask

    task automatic test_random_jobs();
        int ba, bb, cnt, fin_at, done_exp, j;
        logic [31:0] exp_res;
        logic [3:0] exp_st, got_st;
        logic [ADDR_W-1:0] exp_aa, exp_ab;
        for (int t = 0; t < 6; t++) begin
            ba       = $urandom_range(0, DEPTH - 1);
            bb       = $urandom_range(0, DEPTH - 1);
            cnt      = $urandom_range(1, 5);
            fin_at   = $urandom_range(0, 4);
            done_exp = 4 + 2 * cnt + fin_at + 1;
            exp_res  = f32_of(model_dot(ba, bb, cnt));
            drive_job(ba, bb, cnt, fin_at, 1'b0, 1'b0, exp_res);
            n_cmp++;
            if (done_idx != done_exp) begin
                n_bad++;
                $display("FAIL rnd_done job %0d: done at %0d want %0d", t, done_idx, done_exp);
            end
            for (int i = 0; i < n_rec; i++) begin
                j = i - 4;
                exp_st = {i < 2, i <= done_exp, i == 4, i == done_exp};
                got_st = {rec_dpr[i], rec_busy[i], rec_rn[i], rec_rv[i]};
                n_cmp++;
                if (got_st !== exp_st) begin
                    n_bad++;
                    $display("FAIL rnd_flags job %0d cyc %0d: got %b want %b", t, i, got_st, exp_st);
                end
                if (i == 2 || (j >= 0 && j < 2 * cnt && j % 2 == 0 && j / 2 < cnt - 1)) begin
                    exp_aa = (i == 2) ? ADDR_W'(ba) : ADDR_W'(ba + j / 2 + 1);
                    exp_ab = (i == 2) ? ADDR_W'(bb) : ADDR_W'(bb + j / 2 + 1);
                    n_cmp++;
                    if (rec_aa[i] !== exp_aa || rec_ab[i] !== exp_ab) begin
                        n_bad++;
                        $display("FAIL rnd_addr job %0d cyc %0d: got %h/%h want %h/%h", t, i, rec_aa[i], rec_ab[i], exp_aa, exp_ab);
                    end
                end
                if (j >= 0 && i <= done_exp) begin
                    n_cmp++;
                    if (j < 2 * cnt ? (rec_ra[i] !== mem_a[(ba + j / 2) % DEPTH] || rec_rb[i] !== mem_b[(bb + j / 2) % DEPTH])
                                    : ({rec_ra[i], rec_rb[i]} !== '0)) begin
                        n_bad++;
                        $display("FAIL rnd_rows job %0d cyc %0d: row_a low word %h", t, i, rec_ra[i][31:0]);
                    end
                end
            end
            n_cmp++;
            if (rec_res[done_exp] !== exp_res || rec_terr[done_exp] !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_result job %0d: got %h terr %b want %h terr 0", t, rec_res[done_exp], rec_terr[done_exp], exp_res);
            end
        end
    endtask

    task automatic test_zero_count();
        logic addr_seen;
        drive_job(5, 7, 0, -1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (done_idx != 2) begin
            n_bad++;
            $display("FAIL zero_done: done at %0d want 2", done_idx);
        end
        n_cmp++;
        if ({rec_dpr[0], rec_dpr[1], rec_dpr[2], rec_busy[2], rec_busy[3]} !== 5'b11010) begin
            n_bad++;
            $display("FAIL zero_clear: got %b want 11010", {rec_dpr[0], rec_dpr[1], rec_dpr[2], rec_busy[2], rec_busy[3]});
        end
        addr_seen = 1'b0;
        for (int i = 0; i < n_rec; i++)
            if (rec_rn[i] || rec_aa[i] != '0 || rec_ab[i] != '0) addr_seen = 1'b1;
        n_cmp++;
        if (addr_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_no_read: read_now or read address seen, got %b want 0", addr_seen);
        end
        n_cmp++;
        if (rec_res[2] !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_result: got %h want 0", rec_res[2]);
        end
    endtask

    task automatic test_addr_wrap();
        drive_job(DEPTH - 1, 5, 2, 1, 1'b0, 1'b0, f32_of(model_dot(DEPTH - 1, 5, 2)));
        n_cmp++;
        if (rec_aa[2] !== 10'd1023 || rec_aa[4] !== 10'd0 || rec_ab[4] !== 10'd6) begin
            n_bad++;
            $display("FAIL wrap_addr: got %0d,%0d (b %0d) want 1023,0 (b 6)", rec_aa[2], rec_aa[4], rec_ab[4]);
        end
        n_cmp++;
        if (rec_ra[6] !== mem_a[0]) begin
            n_bad++;
            $display("FAIL wrap_data: row_a low word %h want %h", rec_ra[6][31:0], mem_a[0][31:0]);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] exp_res;
        drive_job(10, 20, 2, -1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (done_idx != 8 + TIMEOUT) begin
            n_bad++;
            $display("FAIL to_done: done at %0d want %0d", done_idx, 8 + TIMEOUT);
        end
        n_cmp++;
        if (rec_terr[8] !== 1'b0 || rec_terr[8 + TIMEOUT] !== 1'b1 || rec_res[8 + TIMEOUT] !== 32'h0) begin
            n_bad++;
            $display("FAIL to_flag: terr %b->%b result %h want 0->1 result 0", rec_terr[8], rec_terr[8 + TIMEOUT], rec_res[8 + TIMEOUT]);
        end
        @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL to_hold: terr %b busy %b want 1 0", timeout_err, busy);
        end
        exp_res = f32_of(model_dot(12, 22, 1));
        drive_job(12, 22, 1, 0, 1'b0, 1'b0, exp_res);
        n_cmp++;
        if (rec_terr[0] !== 1'b0 || done_idx != 7 || rec_res[7] !== exp_res) begin
            n_bad++;
            $display("FAIL to_clear: terr %b done %0d result %h want 0 7 %h", rec_terr[0], done_idx, rec_res[7], exp_res);
        end
    endtask

    task automatic test_ignore_inputs();
        int rv_cnt;
        logic [31:0] exp_res;
        exp_res = f32_of(model_dot(30, 40, 3));
        drive_job(30, 40, 3, 3, 1'b1, 1'b1, exp_res);
        rv_cnt = 0;
        for (int i = 0; i < n_rec; i++) rv_cnt += int'(rec_rv[i]);
        n_cmp++;
        if (done_idx != 14 || rv_cnt != 1) begin
            n_bad++;
            $display("FAIL ign_done: done %0d pulses %0d want 14 and 1", done_idx, rv_cnt);
        end
        n_cmp++;
        if (rec_ra[6] !== mem_a[31] || rec_res[14] !== exp_res) begin
            n_bad++;
            $display("FAIL ign_result: result %h want %h", rec_res[14], exp_res);
        end
        n_cmp++;
        if (rec_busy[15] !== 1'b0 || rec_busy[16] !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_restart: busy after done %b%b want 00", rec_busy[15], rec_busy[16]);
        end
    endtask

    task automatic test_reset_mid_job();
        int rv_seen;
        logic [31:0] exp_res;
        @(negedge clk);
        base_addr_a     = 10'd50;
        base_addr_b     = 10'd60;
        no_of_multiples = 32'd3;
        start           = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (first_row_input !== mem_a[51]) begin
            n_bad++;
            $display("FAIL mid_pkg1: row_a low word %h want %h", first_row_input[31:0], mem_a[51][31:0]);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, outsider_read_now, result_valid, dp_reset} !== 4'b0001 || dbg_state !== S_IDLE) begin
            n_bad++;
            $display("FAIL mid_flags: got %b state %0d want 0001 IDLE", {busy, outsider_read_now, result_valid, dp_reset}, dbg_state);
        end
        n_cmp++;
        if ({first_row_input, second_row_input} !== '0 || {mem_addr_a, mem_addr_b} !== '0) begin
            n_bad++;
            $display("FAIL mid_rows: rows/addrs not cleared (row_a low %h)", first_row_input[31:0]);
        end
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        rv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            rv_seen += int'(result_valid);
        end
        n_cmp++;
        if (rv_seen != 0) begin
            n_bad++;
            $display("FAIL mid_no_result: result_valid pulses %0d want 0", rv_seen);
        end
        exp_res = f32_of(model_dot(70, 80, 2));
        drive_job(70, 80, 2, 1, 1'b0, 1'b0, exp_res);
        n_cmp++;
        if (done_idx != 10 || rec_res[10] !== exp_res) begin
            n_bad++;
            $display("FAIL mid_rerun: done %0d result %h want 10 %h", done_idx, rec_res[10], exp_res);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b0;
        start              = 1'b0;
        finish             = 1'b0;
        base_addr_a        = '0;
        base_addr_b        = '0;
        no_of_multiples    = '0;
        dot_product_output = '0;
        mem_data_a         = '0;
        mem_data_b         = '0;
        for (int a = 0; a < DEPTH; a++)
            for (int i = 0; i < NI; i++) begin
                mem_a[a][32*i +: 32] = f32_of($urandom_range(0, 15));
                mem_b[a][32*i +: 32] = f32_of($urandom_range(0, 15));
            end
        test_reset();
        test_directed_48();
        test_random_jobs();
        test_zero_count();
        test_addr_wrap();
        test_timeout();
        test_ignore_inputs();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_product_row_feeder.md
DOT_PRODUCT_ROW_FEEDER -- requirements
Module: dot_product_row_feeder

Interface
REQ-001 Parameter NI, default 8: elements per package (32-bit each); the package width is 32*NI.
REQ-002 Parameter ADDR_W, default 10: width of the package address into the row memories.
REQ-003 Parameter TIMEOUT, default 1024: maximum number of cycles in DRAIN while waiting for finish.
REQ-004 clk  input  1  single clock; all flops rise-edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-006 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-007 base_addr_a, base_addr_b  input  ADDR_W  first package address of row A and of row B.
REQ-008 no_of_multiples  input  32  package count per job; latched on the accepted start.
REQ-009 mem_addr_a, mem_addr_b  output  ADDR_W  read addresses; data returns exactly 1 cycle later.
REQ-010 mem_data_a, mem_data_b  input  32*NI  read data.
REQ-011 first_row_input, second_row_input  output  32*NI  package presented to the dot-product unit.
REQ-012 outsider_read_now  output  1  one-cycle pulse marking the first package.
REQ-013 dp_no_of_multiples  output  32  latched count, driven to the dot-product unit.
REQ-014 dp_reset  output  1  active-high synchronous clear for the dot-product unit.
REQ-015 finish, dot_product_output  input  1, 32  completion flag and result from the dot-product unit.
REQ-016 result  output  32; result_valid  output  1; busy  output  1; timeout_err  output  1.

Function
REQ-017 FSM states are IDLE, CLEAR, FETCH, STREAM, DRAIN, DONE, encoded in 3 bits.
REQ-018 IDLE: busy=0; on start, latch the bases and count, then go to CLEAR; start in any other state is ignored.
REQ-019 CLEAR: dp_reset=1 for exactly 2 cycles, then go to FETCH; if the latched count is 0, go directly to DONE with result=0.
REQ-020 FETCH: drive mem_addr = base for 1 cycle; the returned data is registered onto the row outputs on entry to STREAM.
REQ-021 STREAM: each package is held for exactly 2 cycles (the consumer uses the upper half and then the lower half).
REQ-022 STREAM: outsider_read_now=1 only during the first cycle of package 0.
REQ-023 STREAM prefetch: in hold cycle 1 of package k, drive mem_addr = base+k+1; register the returned data as package k+1 at the end of hold cycle 2.
REQ-024 STREAM exit: after package no_of_multiples-1 completes its 2 cycles, the row outputs become all-zero and the FSM goes to DRAIN.
REQ-025 Address arithmetic is modulo 2^ADDR_W (wraps silently); the package counter is 32 bits.
REQ-026 DRAIN: wait for finish=1 and capture dot_product_output into result, then go to DONE; finish is ignored in every other state.
REQ-027 DRAIN watchdog: after TIMEOUT cycles without finish, set timeout_err=1 and result=0, then go to DONE.
REQ-028 DONE: result_valid=1 for exactly 1 cycle, then go to IDLE; result and timeout_err hold until the next accepted start clears timeout_err.
REQ-029 busy=1 in every state except IDLE.

Reset
REQ-030 When reset=0: state=IDLE, and all outputs are 0 except dp_reset=1, which holds the consumer cleared.
REQ-031 Reset asserted mid-job abandons the job; no result_valid is issued for it.

Structure
REQ-032 A shared package holds the FSM state typedef, the PKG_W=32*NI function, and the TIMEOUT default.
REQ-033 One sub-module is natural: feeder_addr_gen (base latch, package counter, prefetch address, last flag).

Verification
REQ-034 NI=8, count=3, A[k]=all elements k+1, B=all 1.0 -> read_now pulses once; 6 STREAM cycles with package changes every 2 cycles; on finish with model output 48.0, result=48.0 and result_valid pulses once.
REQ-035 count=0 -> CLEAR 2 cycles, then DONE; result=0; no read_now pulse; no memory reads.
REQ-036 base_addr_a=2^ADDR_W-1, count=2 -> mem_addr_a sequence is 1023 then 0.
REQ-037 Consumer never asserts finish, TIMEOUT=16 -> timeout_err=1 and result_valid pulses 16 cycles after DRAIN entry.
REQ-038 reset driven low in STREAM package 1 -> outputs clear in the same cycle, dp_reset=1; a new start after release completes normally.
REQ-039 start held high during DRAIN and a finish pulse asserted during STREAM -> both ignored; exactly one result per job.
